// File: rtl/ccff_loader.sv
// ---------------------------------------------------------------------------
// ccff_loader
//
// Streams a byte-oriented configuration bitstream into a serial chain of
// configuration flip-flops (the "ccff" chain). Bytes arrive on a simple
// valid/ready stream. Each accepted byte is unpacked LSB-first onto ccff_head,
// one bit per prog_clk cycle, with cfg_shift_en high for exactly the cycles
// in which a bit is presented. cfg_shift_en drives an external clock gate, so
// the chain advances only on cycles where a real bit is on ccff_head.
//
// The loader knows the chain length (CHAIN_LEN) and checks that the stream
// ends exactly when the chain is full:
//   - chain full on a byte flagged s_last       -> DONE  (fabric released)
//   - chain full on a byte not flagged s_last   -> ERR   (stream too long)
//   - s_last byte exhausted before chain full   -> ERR   (stream too short)
// Bits of the final byte beyond CHAIN_LEN are dropped and never shifted.
//
// Handshake: a byte transfers on a rising edge of prog_clk where both
// s_valid and s_ready are 1. s_ready is 1 only in FETCH and does not depend
// on s_valid; the source may hold s_valid high for any number of cycles and
// must keep s_data/s_last stable until the transfer edge.
//
// Ports
//   prog_clk     in   single clock, all state updates on the rising edge
//   pReset       in   synchronous active-high reset
//   start        in   begin a programming session (ignored while busy)
//   s_data[7:0]  in   bitstream byte
//   s_valid      in   s_data/s_last valid
//   s_last       in   s_data is the final byte of the bitstream
//   s_ready      out  loader accepts a byte this cycle
//   ccff_head    out  serial data into the chain head (0 when not shifting)
//   cfg_shift_en out  enable for the external chain clock gate
//   busy         out  session in progress (FETCH or SHIFT)
//   done         out  chain fully and correctly loaded
//   error        out  length mismatch detected
//   fabric_reset out  holds user logic in reset until a successful load
// ---------------------------------------------------------------------------
module ccff_loader #(
    parameter int CHAIN_LEN = 12
) (
    input  logic       prog_clk,
    input  logic       pReset,
    input  logic       start,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       ccff_head,
    output logic       cfg_shift_en,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic       fabric_reset
);

    localparam int CNT_W = $clog2(CHAIN_LEN + 1);
    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_SHIFT = 3'd2,
        S_DONE  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;   // bits shifted into the chain this session
    logic [3:0]       byte_idx;  // bits of the current byte already presented
    logic [7:0]       shreg;     // remaining (not yet presented) bits of the byte
    logic             last_q;    // s_last captured with the current byte

    // chain_full wins over byte exhaustion when both happen together.
    logic chain_full;
    logic byte_empty;

    assign chain_full = (bit_cnt == CHAIN_LEN_C);
    assign byte_empty = (byte_idx == 4'd8);

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state        <= S_IDLE;
            s_ready      <= 1'b0;
            ccff_head    <= 1'b0;
            cfg_shift_en <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            fabric_reset <= 1'b1;
            bit_cnt      <= '0;
            byte_idx     <= '0;
            shreg        <= '0;
            last_q       <= 1'b0;
        end else begin
            case (state)
                // IDLE, DONE and ERR all wait for start; the session restarts
                // from an empty chain count and fabric_reset is re-asserted.
                S_IDLE, S_DONE, S_ERR: begin
                    if (start) begin
                        state        <= S_FETCH;
                        s_ready      <= 1'b1;
                        busy         <= 1'b1;
                        done         <= 1'b0;
                        error        <= 1'b0;
                        fabric_reset <= 1'b1;
                        bit_cnt      <= '0;
                        byte_idx     <= '0;
                    end
                end

                // The first bit of an accepted byte is presented directly from
                // s_data on the accept edge, so it appears the very next cycle.
                // The shift register keeps the seven bits still to go.
                S_FETCH: begin
                    if (s_valid) begin
                        state        <= S_SHIFT;
                        s_ready      <= 1'b0;
                        ccff_head    <= s_data[0];
                        cfg_shift_en <= 1'b1;
                        shreg        <= {1'b0, s_data[7:1]};
                        last_q       <= s_last;
                        byte_idx     <= 4'd1;
                        bit_cnt      <= bit_cnt + CNT_W'(1);
                    end
                end

                S_SHIFT: begin
                    if (chain_full) begin
                        // Remaining bits of this byte are discarded.
                        ccff_head    <= 1'b0;
                        cfg_shift_en <= 1'b0;
                        busy         <= 1'b0;
                        if (last_q) begin
                            state        <= S_DONE;
                            done         <= 1'b1;
                            fabric_reset <= 1'b0;
                        end else begin
                            state <= S_ERR;
                            error <= 1'b1;
                        end
                    end else if (byte_empty) begin
                        ccff_head    <= 1'b0;
                        cfg_shift_en <= 1'b0;
                        if (last_q) begin
                            state <= S_ERR;
                            busy  <= 1'b0;
                            error <= 1'b1;
                        end else begin
                            state   <= S_FETCH;
                            s_ready <= 1'b1;
                        end
                    end else begin
                        ccff_head    <= shreg[0];
                        cfg_shift_en <= 1'b1;
                        shreg        <= {1'b0, shreg[7:1]};
                        byte_idx     <= byte_idx + 4'd1;
                        bit_cnt      <= bit_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state        <= S_IDLE;
                    s_ready      <= 1'b0;
                    ccff_head    <= 1'b0;
                    cfg_shift_en <= 1'b0;
                    busy         <= 1'b0;
                    done         <= 1'b0;
                    error        <= 1'b0;
                    fabric_reset <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_loader.sv
// ---------------------------------------------------------------------------
// Testbench for ccff_loader (CHAIN_LEN = 12).
// A session model turns a list of bytes and last flags into the bit sequence
// the chain must receive and the expected outcome; a negedge monitor checks
// every shift pulse against that expected bit queue plus output invariants.
// ---------------------------------------------------------------------------
module tb_ccff_loader;

    localparam int CL = 12;

    logic       prog_clk = 1'b0;
    logic       pReset;
    logic       start;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;
    logic       ccff_head;
    logic       cfg_shift_en;
    logic       busy;
    logic       done;
    logic       error;
    logic       fabric_reset;

    ccff_loader #(.CHAIN_LEN(CL)) dut (
        .prog_clk     (prog_clk),
        .pReset       (pReset),
        .start        (start),
        .s_data       (s_data),
        .s_valid      (s_valid),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .ccff_head    (ccff_head),
        .cfg_shift_en (cfg_shift_en),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .fabric_reset (fabric_reset)
    );

    // ---------------- clock ----------------
    always #5 prog_clk = ~prog_clk;

    // ---------------- scoreboard state ----------------
    int   n_cmp = 0;
    int   n_bad = 0;
    logic exp_q[$];   // bits the chain must still receive, in order
    logic got_q[$];   // bits seen on ccff_head during pulses
    int   pulse_cnt = 0;
    bit   mon_on = 1'b0;
    bit   acc_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge prog_clk) begin
        if (mon_on) begin
            if (cfg_shift_en === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("extra_pulse", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("ccff_head", 32'(ccff_head), 32'(exp_q.pop_front()));
                end
                got_q.push_back(ccff_head);
                pulse_cnt++;
                check("ready_during_shift", 32'(s_ready), 32'd0);
            end else begin
                check("head_when_idle", 32'(ccff_head), 32'd0);
            end
            if (acc_prev) check("first_bit_latency", 32'(cfg_shift_en), 32'd1);
            check("ready_without_busy", 32'(s_ready && !busy), 32'd0);
            check("done_and_error", 32'(done && error), 32'd0);
            check("fabric_reset_vs_done", 32'(fabric_reset), 32'(!done));
            acc_prev = (s_valid === 1'b1) && (s_ready === 1'b1) && (pReset === 1'b0);
        end
    end

    // ---------------- behavioural session model ----------------
    // Concatenate bytes LSB-first, stop at CL bits or at the first last-byte.
    task automatic model(input logic [7:0] d0, input logic [7:0] d1,
                         input bit l0, input bit l1,
                         output logic [15:0] bits, output int nbits,
                         output bit ok_done, output int nbytes);
        logic [7:0] d[2];
        bit         l[2];
        d[0] = d0; d[1] = d1; l[0] = l0; l[1] = l1;
        bits = '0; nbits = 0; ok_done = 1'b0; nbytes = 2;
        for (int j = 0; j < 2; j++) begin
            for (int b = 0; b < 8; b++) begin
                if (nbits < CL) begin
                    bits[nbits] = d[j][b];
                    nbits++;
                end
            end
            if (nbits >= CL) begin
                ok_done = l[j];
                nbytes  = j + 1;
                break;
            end
            if (l[j]) begin
                ok_done = 1'b0;
                nbytes  = j + 1;
                break;
            end
        end
    endtask

    // ---------------- driver tasks (called at posedge+1) ----------------
    task automatic pulse_start();
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] d, input bit l, input int gap, output bit ok);
        int t = 0;
        ok = 1'b1;
        while (s_ready !== 1'b1 && t < 60) begin
            @(posedge prog_clk); #1;
            t++;
        end
        if (s_ready !== 1'b1) begin
            check("ready_timeout", 32'(s_ready), 32'd1);
            ok = 1'b0;
            return;
        end
        for (int g = 0; g < gap; g++) begin
            @(posedge prog_clk); #1;
            check("hold_in_fetch", 32'(s_ready), 32'd1);
        end
        s_data = d; s_last = l; s_valid = 1'b1;
        @(posedge prog_clk); #1;
        s_valid = 1'b0; s_last = 1'b0; s_data = 8'($urandom);
    endtask

    task automatic run_session(input logic [7:0] d0, input logic [7:0] d1,
                               input bit l0, input bit l1, input int gap,
                               input bit poke, output logic [15:0] got);
        logic [15:0] bits;
        int          nbits, nbytes, pc0, t;
        bit          ok_done, ok;
        model(d0, d1, l0, l1, bits, nbits, ok_done, nbytes);
        exp_q.delete();
        got_q.delete();
        for (int i = 0; i < nbits; i++) exp_q.push_back(bits[i]);
        pc0 = pulse_cnt;

        pulse_start();
        check("restart_ready", 32'(s_ready), 32'd1);
        check("restart_busy", 32'(busy), 32'd1);
        check("restart_done", 32'(done), 32'd0);
        check("restart_error", 32'(error), 32'd0);
        check("restart_fabric_reset", 32'(fabric_reset), 32'd1);

        for (int j = 0; j < nbytes; j++) begin
            send_byte((j == 0) ? d0 : d1, (j == 0) ? l0 : l1, gap, ok);
            if (!ok) break;
            if (j == 0 && poke) begin
                @(posedge prog_clk); #1;
                pulse_start();
            end
        end

        t = 0;
        while (busy === 1'b1 && t < 100) begin
            @(posedge prog_clk); #1;
            t++;
        end
        check("session_end", 32'(busy), 32'd0);
        check("pulse_count", 32'(pulse_cnt - pc0), 32'(nbits));
        check("bits_left", 32'(exp_q.size()), 32'd0);
        check("end_done", 32'(done), 32'(ok_done));
        check("end_error", 32'(error), 32'(!ok_done));
        check("end_fabric_reset", 32'(fabric_reset), 32'(!ok_done));
        check("end_ready", 32'(s_ready), 32'd0);
        repeat (3) begin
            @(posedge prog_clk); #1;
        end
        check("hold_ready", 32'(s_ready), 32'd0);
        check("hold_done", 32'(done), 32'(ok_done));
        check("hold_error", 32'(error), 32'(!ok_done));

        got = '0;
        for (int i = 0; i < got_q.size() && i < 16; i++) got[i] = got_q[i];
        exp_q.delete();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] mbits, got;
        int          mn, mb, pc0, t;
        bit          md, ok;
        logic [7:0]  rd0, rd1;

        pReset = 1'b1; start = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;

        // Model pinned against hand-computed results.
        model(8'hA5, 8'h03, 1'b0, 1'b1, mbits, mn, md, mb);
        check("model_034_bits", 32'(mbits), 32'h03A5);
        check("model_034_count", 32'(mn), 32'd12);
        check("model_034_done", 32'(md), 32'd1);
        model(8'hFF, 8'h00, 1'b1, 1'b0, mbits, mn, md, mb);
        check("model_035_count", 32'(mn), 32'd8);
        check("model_035_bytes", 32'(mb), 32'd1);
        model(8'h00, 8'h00, 1'b0, 1'b0, mbits, mn, md, mb);
        check("model_036_count", 32'(mn), 32'd12);
        check("model_036_done", 32'(md), 32'd0);

        // Reset, with start asserted alongside it: reset must win.
        repeat (2) @(posedge prog_clk);
        #1 start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_ccff_head", 32'(ccff_head), 32'd0);
        check("rst_shift_en", 32'(cfg_shift_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_fabric_reset", 32'(fabric_reset), 32'd1);
        pReset = 1'b0;
        mon_on = 1'b1;
        repeat (3) begin
            @(posedge prog_clk); #1;
        end
        check("idle_busy", 32'(busy), 32'd0);

        // Directed sessions.
        run_session(8'hA5, 8'h03, 1'b0, 1'b1, 0, 1'b0, got);
        check("seq_034", 32'(got), 32'h03A5);
        run_session(8'hFF, 8'h00, 1'b1, 1'b0, 0, 1'b0, got);
        check("seq_035", 32'(got), 32'h00FF);
        run_session(8'h00, 8'h00, 1'b0, 1'b0, 0, 1'b0, got);
        run_session(8'hA5, 8'h03, 1'b0, 1'b1, 5, 1'b0, got);
        check("seq_037_backpressure", 32'(got), 32'h03A5);
        run_session(8'hA5, 8'h03, 1'b0, 1'b1, 0, 1'b1, got);
        check("seq_039_start_ignored", 32'(got), 32'h03A5);

        // Reset after the 5th pulse, then a full restart.
        exp_q.delete();
        for (int i = 0; i < 8; i++) exp_q.push_back(i[0] ? 1'b0 : (i == 0 || i == 2 || i == 5 || i == 7));
        pc0 = pulse_cnt;
        pulse_start();
        send_byte(8'hA5, 1'b0, 0, ok);
        t = 0;
        while (pulse_cnt < pc0 + 5 && t < 40) begin
            @(negedge prog_clk); #1;
            t++;
        end
        check("reached_5_pulses", 32'(pulse_cnt - pc0), 32'd5);
        pReset = 1'b1;
        @(posedge prog_clk); #1;
        exp_q.delete();
        pReset = 1'b0;
        check("midrst_shift_en", 32'(cfg_shift_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_fabric_reset", 32'(fabric_reset), 32'd1);
        check("midrst_ready", 32'(s_ready), 32'd0);
        repeat (10) begin
            @(posedge prog_clk); #1;
        end
        check("no_pulse_after_reset", 32'(pulse_cnt - pc0), 32'd5);
        run_session(8'hA5, 8'h03, 1'b0, 1'b1, 0, 1'b0, got);
        check("seq_038_restart", 32'(got), 32'h03A5);

        // Randomized sessions.
        for (int k = 0; k < 30; k++) begin
            rd0 = 8'($urandom);
            rd1 = 8'($urandom);
            run_session(rd0, rd1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        $urandom_range(0, 3), 1'($urandom_range(0, 1)), got);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global watchdog.
    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
